mul4_arbiter: RTL and testbench
===============================

MUL4_ARBITER -- requirements
Module: mul4_arbiter

Interface
REQ-001 Parameter: N, default 4, operand width in bits; product width is 2N.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 a_req_valid  input  1  requester A presents an operation.
REQ-005 a_req_ready  output  1  operation from A accepted this cycle.
REQ-006 a_op_x, a_op_y  input  N each  requester A operands.
REQ-007 a_rsp_valid  output  1  product for A available.
REQ-008 a_rsp_ready  input  1  A consumes the product.
REQ-009 b_req_valid, b_req_ready, b_op_x, b_op_y, b_rsp_valid, b_rsp_ready: same as REQ-004..REQ-008, for requester B.
REQ-010 rsp_data  output  2N  product; shared by both response ports; meaningful only while a_rsp_valid or b_rsp_valid is high.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 op_count  output  8  count of completed responses.

Function
REQ-013 A single unsigned NxN combinational array multiplier SHALL be shared by both requesters; instances per requester are not permitted.
REQ-014 FSM states: IDLE, MUL, RESP; reset state IDLE.
REQ-015 IDLE: if any req_valid is high, exactly one req_ready SHALL be asserted (combinational) for the winner; operands and winner ID are registered; next state MUL.
REQ-016 IDLE, no req_valid: stay IDLE; both req_ready low.
REQ-017 Arbitration is round-robin: if both valid, the requester not served last wins; if only one is valid, it wins regardless of pointer.
REQ-018 The last-served pointer SHALL update only on response handshake completion (rsp_valid & rsp_ready).
REQ-019 MUL: product of the registered operands is captured into the result register (2N bits, no truncation); next state RESP.
REQ-020 RESP: only the winner's rsp_valid is high and rsp_data holds the product; rsp_valid and rsp_data stay stable until the winner's rsp_ready is high.
REQ-021 RESP with the winner's rsp_ready high: handshake completes; op_count increments; next state IDLE.
REQ-022 The non-winner's rsp_ready is ignored; the non-winner's rsp_valid stays low.
REQ-023 req_ready SHALL be low in MUL and RESP; requests presented then are held off, not dropped by the block.
REQ-024 Latency: acceptance in cycle T gives rsp_valid in cycle T+2; minimum spacing between acceptances is 3 cycles.
REQ-025 op_count wraps from 255 to 0.
REQ-026 Operand changes after acceptance SHALL NOT affect the in-flight product.

Reset
REQ-027 With rst high at a rising edge, next cycle: state IDLE; all req_ready and rsp_valid low; busy low; op_count 0; rsp_data 0; pointer set so A wins the first contention.
REQ-028 rst mid-operation (MUL or RESP) SHALL abandon the transaction; no response is issued and op_count is not incremented.
REQ-029 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-030 Single request: A valid, x=15, y=15; expected: a_req_ready high in T, a_rsp_valid high in T+2, rsp_data=225; a_rsp_ready high gives IDLE in T+3 and op_count=1.
REQ-031 Contention after reset: A and B both valid continuously, A=(3,5), B=(7,9); expected: A is served first with rsp_data=15, then B with rsp_data=63, then A again; the grants strictly alternate.
REQ-032 Backpressure: B served with x=12, y=10 while b_rsp_ready is held low for 5 cycles; expected: b_rsp_valid and rsp_data=120 stay stable for all 5 cycles; a_req_ready stays low throughout.
REQ-033 Wrong-port ready: A in RESP with a_rsp_ready low and b_rsp_ready high; expected: no handshake, state stays RESP, op_count unchanged.
REQ-034 Reset mid-operation: rst asserted in the MUL cycle of an A request; expected: no a_rsp_valid pulse, op_count=0, A wins the next contention.
REQ-035 Wrap and zero: run 256 completions, including x=0, y=9 (expected product 0); expected: op_count reads 0 after the 256th completion.

Source files
------------

// File: rtl/mul4_arbiter.sv
// Two-requester front end to a single shared unsigned NxN array multiplier.
// Round-robin grant in IDLE, one product per transaction, held until the winner consumes it.
module mul4_arbiter #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           a_req_valid,
   output logic           a_req_ready,
   input  logic [N-1:0]   a_op_x,
   input  logic [N-1:0]   a_op_y,
   output logic           a_rsp_valid,
   input  logic           a_rsp_ready,
   input  logic           b_req_valid,
   output logic           b_req_ready,
   input  logic [N-1:0]   b_op_x,
   input  logic [N-1:0]   b_op_y,
   output logic           b_rsp_valid,
   input  logic           b_rsp_ready,
   output logic [2*N-1:0] rsp_data,
   output logic           busy,
   output logic [7:0]     op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   logic           winner;     // 1'b0 = A, 1'b1 = B
   logic           last;       // requester whose response completed most recently
   logic [N-1:0]   op_x;
   logic [N-1:0]   op_y;
   logic           grant_b;
   logic [2*N-1:0] product;

   // Shift-and-add array multiplier; the only multiplier in the block.
   function automatic logic [2*N-1:0] array_mul(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [2*N-1:0] acc;
      acc = {(2*N){1'b0}};
      for (int i = 0; i < N; i++) begin
         if (y[i]) begin
            acc = acc + ({{N{1'b0}}, x} << i);
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction

   // Shared product of the captured operands.
   always_comb begin
      product = array_mul(op_x, op_y);
   end

   // Round-robin grant decision; only one requester valid always wins.
   always_comb begin
      grant_b = 1'b0;
      if (a_req_valid && b_req_valid) begin
         grant_b = ~last;
      end else if (b_req_valid) begin
         grant_b = 1'b1;
      end else begin
         grant_b = 1'b0;
      end
   end

   // Acceptance strobes; suppressed while reset is asserted so reset wins the cycle.
   always_comb begin
      a_req_ready = 1'b0;
      b_req_ready = 1'b0;
      if (!rst && (state == IDLE)) begin
         a_req_ready = a_req_valid & ~grant_b;
         b_req_ready = b_req_valid & grant_b;
      end else begin
         a_req_ready = 1'b0;
         b_req_ready = 1'b0;
      end
   end

   // Transaction FSM with registered response, status and counter outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         winner      <= 1'b0;
         last        <= 1'b1;
         op_x        <= {N{1'b0}};
         op_y        <= {N{1'b0}};
         a_rsp_valid <= 1'b0;
         b_rsp_valid <= 1'b0;
         rsp_data    <= {(2*N){1'b0}};
         busy        <= 1'b0;
         op_count    <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (a_req_valid || b_req_valid) begin
                  winner <= grant_b;
                  op_x   <= grant_b ? b_op_x : a_op_x;
                  op_y   <= grant_b ? b_op_y : a_op_y;
                  busy   <= 1'b1;
                  state  <= MUL;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            MUL: begin
               rsp_data    <= product;
               a_rsp_valid <= ~winner;
               b_rsp_valid <= winner;
               state       <= RESP;
            end
            RESP: begin
               // The loser's rsp_ready is deliberately not looked at.
               if (winner ? b_rsp_ready : a_rsp_ready) begin
                  a_rsp_valid <= 1'b0;
                  b_rsp_valid <= 1'b0;
                  busy        <= 1'b0;
                  last        <= winner;
                  op_count    <= op_count + 8'd1;
                  state       <= IDLE;
               end else begin
                  state <= RESP;
               end
            end
            default: begin
               a_rsp_valid <= 1'b0;
               b_rsp_valid <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul4_arbiter.sv
// Randomized self-checking bench for mul4_arbiter against a transaction-level model
// (expected product = x*y, completion counter mod 256, next contention winner).
module tb_mul4_arbiter;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           a_req_valid = 1'b0, b_req_valid = 1'b0;
   logic           a_req_ready, b_req_ready;
   logic [N-1:0]   a_op_x = '0, a_op_y = '0, b_op_x = '0, b_op_y = '0;
   logic           a_rsp_valid, b_rsp_valid;
   logic           a_rsp_ready = 1'b0, b_rsp_ready = 1'b0;
   logic [2*N-1:0] rsp_data;
   logic           busy;
   logic [7:0]     op_count;

   int   checks = 0;
   int   errors = 0;
   int   exp_count = 0;   // model: completions mod 256
   bit   pref_b = 1'b0;   // model: B wins the next contention

   mul4_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
      .a_op_x(a_op_x), .a_op_y(a_op_y),
      .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
      .b_op_x(b_op_x), .b_op_y(b_op_y),
      .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
      .rsp_data(rsp_data), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_req_valid = 1'b1;
      b_req_valid = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if (a_req_ready || b_req_ready || a_rsp_valid || b_rsp_valid || busy || op_count !== 8'd0 || rsp_data !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: req_ready=%b%b rsp_valid=%b%b busy=%b op_count=%0d rsp_data=%0d, required all zero",
                  a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, busy, op_count, rsp_data);
      end
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      rst = 1'b0;
      exp_count = 0;
      pref_b = 1'b0;
      tick();
   endtask

   // One full transaction for the chosen requester, with optional contention and backpressure.
   task automatic serve(input bit use_b, input logic [N-1:0] x, input logic [N-1:0] y,
                        input int hold, input bit contend);
      logic [2*N-1:0] exp_p;
      int waited;
      logic own_rv, oth_rv, oth_rdy;
      exp_p = (2*N)'(int'(x) * int'(y));
      if (use_b) begin
         b_req_valid = 1'b1; b_op_x = x; b_op_y = y;
         a_req_valid = contend; a_op_x = N'($urandom); a_op_y = N'($urandom);
      end else begin
         a_req_valid = 1'b1; a_op_x = x; a_op_y = y;
         b_req_valid = contend; b_op_x = N'($urandom); b_op_y = N'($urandom);
      end
      #1;
      waited = 0;
      while (!(use_b ? b_req_ready : a_req_ready) && waited < 10) begin
         tick();
         #1;
         waited++;
      end
      checks++;
      if (!(use_b ? b_req_ready : a_req_ready) || (use_b ? a_req_ready : b_req_ready)) begin
         errors++;
         $display("FAIL grant: a_req_ready=%b b_req_ready=%b, required winner %s only",
                  a_req_ready, b_req_ready, use_b ? "B" : "A");
      end
      tick();
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      a_op_x = N'($urandom); a_op_y = N'($urandom);
      b_op_x = N'($urandom); b_op_y = N'($urandom);
      #1;
      checks++;
      if (a_rsp_valid || b_rsp_valid || !busy || a_req_ready || b_req_ready) begin
         errors++;
         $display("FAIL mul_cycle: rsp_valid=%b%b busy=%b req_ready=%b%b, required rsp_valid 00 busy 1 req_ready 00",
                  a_rsp_valid, b_rsp_valid, busy, a_req_ready, b_req_ready);
      end
      tick();
      #1;
      own_rv = use_b ? b_rsp_valid : a_rsp_valid;
      oth_rv = use_b ? a_rsp_valid : b_rsp_valid;
      checks++;
      if (!own_rv || oth_rv || rsp_data !== exp_p) begin
         errors++;
         $display("FAIL response: own_valid=%b other_valid=%b rsp_data=%0d, required 1 0 %0d",
                  own_rv, oth_rv, rsp_data, exp_p);
      end
      for (int h = 0; h < hold; h++) begin
         if (use_b) begin
            b_rsp_ready = 1'b0; a_req_valid = 1'b1; a_rsp_ready = 1'b1;
         end else begin
            a_rsp_ready = 1'b0; b_req_valid = 1'b1; b_rsp_ready = 1'b1;
         end
         #1;
         own_rv  = use_b ? b_rsp_valid : a_rsp_valid;
         oth_rv  = use_b ? a_rsp_valid : b_rsp_valid;
         oth_rdy = use_b ? a_req_ready : b_req_ready;
         checks++;
         if (!own_rv || oth_rv || rsp_data !== exp_p || oth_rdy || !busy || op_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL hold_%0d: own_valid=%b other_valid=%b rsp_data=%0d other_req_ready=%b busy=%b op_count=%0d, required 1 0 %0d 0 1 %0d",
                     h, own_rv, oth_rv, rsp_data, oth_rdy, busy, op_count, exp_p, exp_count);
         end
         tick();
      end
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      a_rsp_ready = ~use_b; b_rsp_ready = use_b;
      tick();
      a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
      exp_count = (exp_count + 1) % 256;
      pref_b = ~use_b;
      #1;
      checks++;
      if (busy || a_rsp_valid || b_rsp_valid || op_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL completion: busy=%b rsp_valid=%b%b op_count=%0d, required 0 00 %0d",
                  busy, a_rsp_valid, b_rsp_valid, op_count, exp_count);
      end
   endtask

   task automatic test_contention();
      int grants = 0;
      int pend = -1;
      bit pend_b = 1'b0;
      logic [2*N-1:0] exp_p;
      a_op_x = 4'd3; a_op_y = 4'd5; b_op_x = 4'd7; b_op_y = 4'd9;
      a_req_valid = 1'b1; b_req_valid = 1'b1;
      a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (pend >= 0 && c == pend + 2) begin
            exp_p = pend_b ? 8'd63 : 8'd15;
            checks++;
            if ((pend_b ? !b_rsp_valid : !a_rsp_valid) || (pend_b ? a_rsp_valid : b_rsp_valid) || rsp_data !== exp_p) begin
               errors++;
               $display("FAIL contention_rsp_%0d: rsp_valid=%b%b rsp_data=%0d, required %s with %0d",
                        grants, a_rsp_valid, b_rsp_valid, rsp_data, pend_b ? "B" : "A", exp_p);
            end
            exp_count = (exp_count + 1) % 256;
            pref_b = ~pend_b;
            if (grants == 4) begin
               a_req_valid = 1'b0; b_req_valid = 1'b0;
               break;
            end
         end else if (a_req_ready || b_req_ready) begin
            checks++;
            if ((a_req_ready && b_req_ready) || (b_req_ready != pref_b)) begin
               errors++;
               $display("FAIL contention_grant_%0d: a_req_ready=%b b_req_ready=%b, required winner %s",
                        grants, a_req_ready, b_req_ready, pref_b ? "B" : "A");
            end
            if (grants > 0) begin
               checks++;
               if (c != pend + 3) begin
                  errors++;
                  $display("FAIL contention_spacing: grant at cycle %0d, required %0d", c, pend + 3);
               end
            end
            pend = c;
            pend_b = b_req_ready;
            grants++;
         end
         tick();
      end
      checks++;
      if (grants != 4) begin
         errors++;
         $display("FAIL contention_count: %0d grants seen, required 4", grants);
      end
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      tick();
      a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
      #1;
      checks++;
      if (busy || op_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL contention_end: busy=%b op_count=%0d, required 0 %0d", busy, op_count, exp_count);
      end
   endtask

   task automatic test_single();
      serve(1'b0, 4'd15, 4'd15, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      serve(1'b1, 4'd12, 4'd10, 5, 1'b0);
   endtask

   task automatic test_wrong_port();
      serve(1'b0, 4'd9, 4'd11, 3, 1'b0);
   endtask

   task automatic test_reset_mid();
      a_req_valid = 1'b1; a_op_x = 4'd6; a_op_y = 4'd7;
      #1;
      checks++;
      if (!a_req_ready) begin
         errors++;
         $display("FAIL reset_mid_grant: a_req_ready=%b, required 1", a_req_ready);
      end
      tick();
      a_req_valid = 1'b0;
      rst = 1'b1;
      a_rsp_ready = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (a_rsp_valid || b_rsp_valid || busy || op_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_%0d: rsp_valid=%b%b busy=%b op_count=%0d, required 00 0 0",
                     k, a_rsp_valid, b_rsp_valid, busy, op_count);
         end
         tick();
      end
      a_rsp_ready = 1'b0;
      exp_count = 0;
      pref_b = 1'b0;
      serve(1'b0, 4'd2, 4'd3, 0, 1'b1);
   endtask

   task automatic test_wrap();
      bit contend, use_b;
      logic [N-1:0] x, y;
      int remaining;
      remaining = 256 - exp_count;
      for (int i = 0; i < remaining; i++) begin
         contend = 1'($urandom);
         use_b = contend ? pref_b : 1'($urandom);
         x = N'($urandom);
         y = N'($urandom);
         if (i == 0) begin
            x = 4'd0; y = 4'd9;
         end
         serve(use_b, x, y, int'($urandom_range(0, 2)), contend);
      end
      checks++;
      if (op_count !== 8'd0) begin
         errors++;
         $display("FAIL wrap: op_count=%0d, required 0", op_count);
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_backpressure();
      test_wrong_port();
      test_reset_mid();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
